// File: rtl/mmss_timer_core.sv
// MM:SS up/down timer core with countdown expiry, adjust mode and wrap flag.
// Optional lap hold of the displayed digits is enabled by defining LAP_EN.
module mmss_timer_core #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned ADJ_HZ      = 2,
  parameter int unsigned MAX_MINUTES = 99
) (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_pause,
  input  logic       in_adjust,
  input  logic       in_select,
  input  logic       in_down,
  input  logic       in_lap,
  output logic [3:0] out_minute1,
  output logic [3:0] out_minute0,
  output logic [3:0] out_second1,
  output logic [3:0] out_second0,
  output logic       out_running,
  output logic       out_expired,
  output logic       out_wrap,
  output logic       out_tick
);

  localparam int unsigned AdjDiv  = ((CLK_HZ / ADJ_HZ) >= 1) ? (CLK_HZ / ADJ_HZ) : 1;
  localparam int unsigned CntW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned AdjW    = (AdjDiv > 1) ? $clog2(AdjDiv) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_HZ - 1);
  localparam logic [AdjW-1:0] AdjLast = AdjW'(AdjDiv - 1);
  localparam logic [7:0] MaxMm = {4'(MAX_MINUTES / 10), 4'(MAX_MINUTES % 10)};

  // Two-digit BCD helpers; callers handle the field-specific wrap points.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    else                return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
    else                return {v[7:4], v[3:0] - 4'd1};
  endfunction

  logic [7:0]      mm_q, mm_d, ss_q, ss_d;
  logic [CntW-1:0] cnt_div_q, cnt_div_d;
  logic [AdjW-1:0] adj_div_q, adj_div_d;
  logic            running_q, running_d;
  logic            expired_q, expired_d;
  logic            wrap_q, wrap_d;
  logic            tick_q, tick_d;
  logic            pause_q;
  logic            pause_rise, cnt_tick, adj_step, next_zero;

  always_comb begin
    pause_rise = in_pause & ~pause_q;
    cnt_tick   = running_q & ~in_adjust & (cnt_div_q == CntLast);
    adj_step   = in_adjust & (adj_div_q == AdjLast);
    // Clearing on the pre-toggle running state gives a full second after resume.
    cnt_div_d  = (in_adjust | ~running_q | cnt_tick) ? '0 : cnt_div_q + CntW'(1);
    adj_div_d  = (~in_adjust | adj_step) ? '0 : adj_div_q + AdjW'(1);
    running_d  = running_q ^ pause_rise;

    mm_d      = mm_q;
    ss_d      = ss_q;
    wrap_d    = 1'b0;
    tick_d    = 1'b0;
    expired_d = expired_q;

    if (adj_step) begin
      tick_d = 1'b1;
      if (in_select) ss_d = (ss_q == 8'h59) ? 8'h00 : bcd_inc(ss_q);
      else           mm_d = (mm_q == MaxMm) ? 8'h00 : bcd_inc(mm_q);
    end else if (cnt_tick) begin
      if (!in_down) begin
        tick_d = 1'b1;
        if (ss_q == 8'h59) begin
          ss_d = 8'h00;
          if (mm_q == MaxMm) begin
            mm_d   = 8'h00;
            wrap_d = 1'b1;
          end else begin
            mm_d = bcd_inc(mm_q);
          end
        end else begin
          ss_d = bcd_inc(ss_q);
        end
      end else if ((mm_q != 8'h00) || (ss_q != 8'h00)) begin
        tick_d = 1'b1;
        if (ss_q == 8'h00) begin
          ss_d = 8'h59;
          mm_d = bcd_dec(mm_q);
        end else begin
          ss_d = bcd_dec(ss_q);
        end
      end
    end

    next_zero = (mm_d == 8'h00) && (ss_d == 8'h00);
    if (cnt_tick && in_down && next_zero) expired_d = 1'b1;
    if (adj_step && !next_zero)           expired_d = 1'b0;
    if (!in_down)                         expired_d = 1'b0;
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      mm_q      <= 8'h00;
      ss_q      <= 8'h00;
      cnt_div_q <= '0;
      adj_div_q <= '0;
      running_q <= 1'b1;
      expired_q <= 1'b0;
      wrap_q    <= 1'b0;
      tick_q    <= 1'b0;
      pause_q   <= 1'b0;
    end else begin
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      cnt_div_q <= cnt_div_d;
      adj_div_q <= adj_div_d;
      running_q <= running_d;
      expired_q <= expired_d;
      wrap_q    <= wrap_d;
      tick_q    <= tick_d;
      pause_q   <= in_pause;
    end
  end

  logic [7:0] disp_mm, disp_ss;

`ifdef LAP_EN
  logic       lap_in_q, lap_on_q, lap_on_d, lap_rise;
  logic [7:0] lap_mm_q, lap_mm_d, lap_ss_q, lap_ss_d;

  always_comb begin
    lap_rise = in_lap & ~lap_in_q;
    lap_on_d = lap_on_q ^ lap_rise;
    lap_mm_d = (lap_rise & ~lap_on_q) ? mm_q : lap_mm_q;
    lap_ss_d = (lap_rise & ~lap_on_q) ? ss_q : lap_ss_q;
  end

  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      lap_in_q <= 1'b0;
      lap_on_q <= 1'b0;
      lap_mm_q <= 8'h00;
      lap_ss_q <= 8'h00;
    end else begin
      lap_in_q <= in_lap;
      lap_on_q <= lap_on_d;
      lap_mm_q <= lap_mm_d;
      lap_ss_q <= lap_ss_d;
    end
  end

  assign disp_mm = lap_on_q ? lap_mm_q : mm_q;
  assign disp_ss = lap_on_q ? lap_ss_q : ss_q;
`else
  logic unused_lap;
  assign unused_lap = in_lap;
  assign disp_mm    = mm_q;
  assign disp_ss    = ss_q;
`endif

  assign out_minute1 = disp_mm[7:4];
  assign out_minute0 = disp_mm[3:0];
  assign out_second1 = disp_ss[7:4];
  assign out_second0 = disp_ss[3:0];
  assign out_running = running_q;
  assign out_expired = expired_q;
  assign out_wrap    = wrap_q;
  assign out_tick    = tick_q;

endmodule

// File: tb/tb_mmss_timer_core.sv
// Bench for mmss_timer_core: step table with scoreboard plus hand sequences for
// wrap, async reset, reduced minute range and (with LAP_EN) lap hold.
module tb_mmss_timer_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pause = 1'b0, adjust = 1'b0, sel = 1'b0, down = 1'b0, lap = 1'b0;
  logic [3:0] m1, m0, s1, s0;
  logic       running, expired, wrap, tick;

  logic       rst5 = 1'b1, adj5 = 1'b0, sel5 = 1'b0, zero5 = 1'b0;
  logic [3:0] f_m1, f_m0, f_s1, f_s0;
  logic       f_running, f_expired, f_wrap, f_tick;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mmss_timer_core #(.CLK_HZ(10), .ADJ_HZ(2), .MAX_MINUTES(99)) dut (
    .in_clock(clk), .in_reset(rst), .in_pause(pause), .in_adjust(adjust),
    .in_select(sel), .in_down(down), .in_lap(lap),
    .out_minute1(m1), .out_minute0(m0), .out_second1(s1), .out_second0(s0),
    .out_running(running), .out_expired(expired), .out_wrap(wrap), .out_tick(tick)
  );

  mmss_timer_core #(.CLK_HZ(10), .ADJ_HZ(2), .MAX_MINUTES(5)) dut5 (
    .in_clock(clk), .in_reset(rst5), .in_pause(zero5), .in_adjust(adj5),
    .in_select(sel5), .in_down(zero5), .in_lap(zero5),
    .out_minute1(f_m1), .out_minute0(f_m0), .out_second1(f_s1), .out_second0(f_s0),
    .out_running(f_running), .out_expired(f_expired), .out_wrap(f_wrap), .out_tick(f_tick)
  );

  typedef struct {
    string       name;
    int          cycles;
    logic        pause, adjust, sel, down;
    logic [15:0] digits;
    logic        running, expired;
    int          ticks;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] digits;
    logic        running, expired;
    int          ticks;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input int cycles, input logic p, input logic a,
                     input logic s, input logic d, input logic [15:0] dg, input logic r,
                     input logic e, input int t);
    vec_t v;
    v.name = name; v.cycles = cycles; v.pause = p; v.adjust = a; v.sel = s; v.down = d;
    v.digits = dg; v.running = r; v.expired = e; v.ticks = t;
    vecs.push_back(v);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expectation queued at drive time, popped once the cycles have elapsed.
  task automatic run_check(input string name, input int n, input logic [15:0] dg,
                           input logic r, input logic e, input int tk);
    exp_t x;
    int   ticks = 0;
    x.name = name; x.digits = dg; x.running = r; x.expired = e; x.ticks = tk;
    sb_q.push_back(x);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (tick) ticks++;
    end
    x = sb_q.pop_front();
    check({x.name, ".digits"}, int'({m1, m0, s1, s0}), int'(x.digits));
    check({x.name, ".running"}, int'(running), int'(x.running));
    check({x.name, ".expired"}, int'(expired), int'(x.expired));
    check({x.name, ".ticks"}, ticks, x.ticks);
  endtask

  initial begin
    //   name            cyc  p  a  s  d  digits    r  e  ticks
    add("up_0002",        20, 0, 0, 0, 0, 16'h0002, 1, 0, 2);
    add("down_zero",      20, 0, 0, 0, 1, 16'h0000, 1, 1, 2);
    add("down_hold",      30, 0, 0, 0, 1, 16'h0000, 1, 1, 0);
    add("down_clear",      1, 0, 0, 0, 0, 16'h0000, 1, 0, 0);
    add("up_0003",        29, 0, 0, 0, 0, 16'h0003, 1, 0, 3);
    add("pause_hold",     50, 1, 0, 0, 0, 16'h0003, 0, 0, 0);
    add("pause_release",   1, 0, 0, 0, 0, 16'h0003, 0, 0, 0);
    add("resume_press",    1, 1, 0, 0, 0, 16'h0003, 1, 0, 0);
    add("resume_9",        9, 1, 0, 0, 0, 16'h0003, 1, 0, 0);
    add("resume_10",       1, 1, 0, 0, 0, 16'h0004, 1, 0, 1);
    add("pause2_release",  1, 0, 0, 0, 0, 16'h0004, 1, 0, 0);
    add("pause2_press",    1, 1, 0, 0, 0, 16'h0004, 0, 0, 0);
    add("adj_min_99",    495, 1, 1, 0, 0, 16'h9904, 0, 0, 99);
    add("adj_min_wrap",    5, 1, 1, 0, 0, 16'h0004, 0, 0, 1);
    add("adj_min_07",     35, 1, 1, 0, 0, 16'h0704, 0, 0, 7);
    add("adj_sec_58",    270, 1, 1, 1, 0, 16'h0758, 0, 0, 54);
    add("adj_sec_59",      5, 1, 1, 1, 0, 16'h0759, 0, 0, 1);
    add("adj_sec_wrap",    5, 1, 1, 1, 0, 16'h0700, 0, 0, 1);
    add("adj_min_12",     25, 1, 1, 0, 0, 16'h1200, 0, 0, 5);
    add("adj_sec_34",    170, 1, 1, 1, 0, 16'h1234, 0, 0, 34);
    add("unpause_rel",     1, 0, 0, 0, 0, 16'h1234, 0, 0, 0);
    add("unpause",         1, 1, 0, 0, 0, 16'h1234, 1, 0, 0);
    add("mid_second",      4, 1, 0, 0, 0, 16'h1234, 1, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    rst5 = 1'b0;
    check("reset.digits", int'({m1, m0, s1, s0}), 0);
    check("reset.running", int'(running), 1);
    check("reset.expired", int'(expired), 0);
    check("reset.wrap", int'(wrap), 0);
    check("reset.tick", int'(tick), 0);

    for (int i = 0; i < vecs.size(); i++) begin
      pause  = vecs[i].pause;
      adjust = vecs[i].adjust;
      sel    = vecs[i].sel;
      down   = vecs[i].down;
      run_check(vecs[i].name, vecs[i].cycles, vecs[i].digits, vecs[i].running,
                vecs[i].expired, vecs[i].ticks);
    end

    // Asynchronous reset mid-second: no clock edge needed.
    rst   = 1'b1;
    pause = 1'b0;
    #1;
    check("async_reset.digits", int'({m1, m0, s1, s0}), 0);
    check("async_reset.running", int'(running), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    run_check("up_0059", 590, 16'h0059, 1, 0, 59);
    run_check("up_0100", 10, 16'h0100, 1, 0, 1);

    adjust = 1'b1;
    sel    = 1'b0;
    run_check("adj_to_9900", 490, 16'h9900, 1, 0, 98);
    sel = 1'b1;
    run_check("adj_to_9959", 295, 16'h9959, 1, 0, 59);
    adjust = 1'b0;
    run_check("pre_wrap", 9, 16'h9959, 1, 0, 0);
    check("pre_wrap.wrap", int'(wrap), 0);
    run_check("wrap", 1, 16'h0000, 1, 0, 1);
    check("wrap.pulse", int'(wrap), 1);
    run_check("post_wrap", 1, 16'h0000, 1, 0, 0);
    check("post_wrap.wrap", int'(wrap), 0);

    // Reduced minute range instance.
    rst5 = 1'b1;
    #1;
    check("max5.reset", int'({f_m1, f_m0, f_s1, f_s0}), 0);
    @(posedge clk);
    #1;
    rst5 = 1'b0;
    adj5 = 1'b1;
    sel5 = 1'b0;
    cyc(25);
    check("max5.adj_min5", int'({f_m1, f_m0, f_s1, f_s0}), 'h0500);
    cyc(5);
    check("max5.adj_wrap", int'({f_m1, f_m0, f_s1, f_s0}), 'h0000);
    check("max5.adj_nowrap", int'(f_wrap), 0);
    cyc(25);
    sel5 = 1'b1;
    cyc(295);
    check("max5.adj_0559", int'({f_m1, f_m0, f_s1, f_s0}), 'h0559);
    adj5 = 1'b0;
    cyc(9);
    check("max5.pre_wrap", int'(f_wrap), 0);
    cyc(1);
    check("max5.wrap_digits", int'({f_m1, f_m0, f_s1, f_s0}), 'h0000);
    check("max5.wrap_pulse", int'(f_wrap), 1);

`ifdef LAP_EN
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_check("lap_run", 50, 16'h0005, 1, 0, 5);
    lap = 1'b1;
    run_check("lap_press", 1, 16'h0005, 1, 0, 0);
    lap = 1'b0;
    run_check("lap_hold", 48, 16'h0005, 1, 0, 4);
    lap = 1'b1;
    run_check("lap_release", 1, 16'h0010, 1, 0, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
